// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the RV32I 5-stage core.
// Contents:
//   state_t - hazard sequencer FSM state encoding
//   REG_X0  - architectural zero register index
//   OPC_*   - major opcodes already used by the pipeline registers
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Stall / flush performance counters for the hazard sequencer.
// Ports:
//   clk_i           - system clock
//   clr_i           - synchronous clear of both counters
//   stall_inc_i     - count one stall cycle
//   flush_inc_i     - count one redirect flush
//   stall_cycles_o  - stall cycle count (wraps)
//   flush_events_o  - redirect flush count (wraps)
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             stall_inc_i,
  input  logic             flush_inc_i,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_events_o
);

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  // Next-count logic; counters wrap naturally.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (clr_i) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (stall_inc_i) begin
        stall_d = stall_q + CNT_W'(1);
      end else begin
        stall_d = stall_q;
      end
      if (flush_inc_i) begin
        flush_d = flush_q + CNT_W'(1);
      end else begin
        flush_d = flush_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    stall_q <= stall_d;
    flush_q <= flush_d;
  end

  assign stall_cycles_o = stall_q;
  assign flush_events_o = flush_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32I pipeline.
// Resolves load-use hazards, EX redirects and multi-cycle dmem waits, with a
// dmem wait watchdog that latches a sticky halt.
// Ports:
//   clk, rst_n (sync, active-low)
//   id_rs1/id_rs2/id_use_rs1/id_use_rs2 - ID source operands
//   ex_rd/ex_is_load/ex_wr_reg_n         - EX destination info
//   ex_redirect                          - EX jump / taken branch
//   dmem_req/dmem_ready                  - MEM stage handshake
//   *_stall / *_flush                    - per-stage hold / bubble enables
//   halt                                 - sticky dmem timeout
//   stall_cycles/flush_events            - performance counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_wr_reg_n,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic             lu_s, ms_s, run_rules_s, redirect_fire_s;

  // Next-state and output decode.
  always_comb begin
    lu_s = ex_is_load & ~ex_wr_reg_n & (ex_rd != REG_X0) &
           ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    ms_s = dmem_req & ~dmem_ready;

    state_d         = state_q;
    wait_d          = wait_q;
    run_rules_s     = 1'b0;
    redirect_fire_s = 1'b0;
    pc_stall        = 1'b0;
    if_id_stall     = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_stall     = 1'b0;
    id_ex_flush     = 1'b0;
    ex_mem_stall    = 1'b0;
    mem_wb_flush    = 1'b0;
    halt            = 1'b0;

    case (state_q)
      ST_RUN: begin
        run_rules_s = 1'b1;
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          // Pipeline frozen: redirect and load-use wait until release.
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_stall = 1'b1;
          mem_wb_flush = 1'b1;
          if (wait_q == WCW'(TIMEOUT - 1)) begin
            state_d = ST_ERROR;
          end else begin
            wait_d = wait_q + WCW'(1);
          end
        end else begin
          // Release cycle behaves as RUN (ms is necessarily 0 here).
          run_rules_s = 1'b1;
          state_d     = ST_RUN;
          wait_d      = '0;
        end
      end
      ST_ERROR: begin
        halt         = 1'b1;
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase

    if (run_rules_s) begin
      if (ms_s) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
        state_d      = ST_MEM_WAIT;
        wait_d       = WCW'(1);
      end else if (ex_redirect) begin
        // Redirect beats load-use: the ID instruction is discarded anyway.
        if_id_flush     = 1'b1;
        id_ex_flush     = 1'b1;
        redirect_fire_s = 1'b1;
      end else if (lu_s) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end else begin
        pc_stall = 1'b0;
      end
    end else begin
      redirect_fire_s = 1'b0;
    end

    if (!rst_n) begin
      pc_stall        = 1'b0;
      if_id_stall     = 1'b0;
      id_ex_stall     = 1'b0;
      ex_mem_stall    = 1'b0;
      if_id_flush     = 1'b1;
      id_ex_flush     = 1'b1;
      mem_wb_flush    = 1'b1;
      halt            = 1'b0;
      redirect_fire_s = 1'b0;
    end else begin
      halt = halt;
    end
  end

  // FSM state and watchdog counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  hazard_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk_i          (clk),
    .clr_i          (~rst_n),
    .stall_inc_i    (pc_stall),
    .flush_inc_i    (redirect_fire_s),
    .stall_cycles_o (stall_cycles),
    .flush_events_o (flush_events)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (TIMEOUT=4). Stimulus pushes expected
// outputs into a queue; a monitor pops and compares on each falling edge.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_is_load, ex_wr_reg_n, ex_redirect;
  logic        dmem_req, dmem_ready;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic        ex_mem_stall, mem_wb_flush, halt;
  logic [31:0] stall_cycles, flush_events;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_wr_reg_n(ex_wr_reg_n),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .mem_wb_flush(mem_wb_flush), .halt(halt),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  // ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush, halt}
  localparam logic [7:0] C_Z   = 8'b0000_0000;
  localparam logic [7:0] C_RST = 8'b0010_1010;
  localparam logic [7:0] C_LU  = 8'b1100_1000;
  localparam logic [7:0] C_RD  = 8'b0010_1000;
  localparam logic [7:0] C_MS  = 8'b1101_0110;
  localparam logic [7:0] C_ERR = 8'b1101_0111;

  typedef struct {
    logic [7:0]  ctl;
    logic [31:0] sc;
    logic [31:0] fe;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor: compare the DUT against the oldest expected entry.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = q.pop_front();
      act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
             ex_mem_stall, mem_wb_flush, halt};
      checks += 3;
      if (act !== e.ctl) begin
        failures++;
        $display("FAIL %s ctl got=%b want=%b", e.name, act, e.ctl);
      end
      if (stall_cycles !== e.sc) begin
        failures++;
        $display("FAIL %s stall_cycles got=%0d want=%0d", e.name, stall_cycles, e.sc);
      end
      if (flush_events !== e.fe) begin
        failures++;
        $display("FAIL %s flush_events got=%0d want=%0d", e.name, flush_events, e.fe);
      end
    end
  end

  // One cycle: drive inputs just after the edge and queue the expectation.
  task automatic step(input logic rn, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic ld, input logic wrn, input logic redir,
                      input logic req, input logic rdy,
                      input logic [7:0] ctl, input int sc, input int fe, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_is_load = ld; ex_wr_reg_n = wrn; ex_redirect = redir;
    dmem_req = req; dmem_ready = rdy;
    e.ctl = ctl; e.sc = 32'(sc); e.fe = 32'(fe); e.name = name;
    q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_wr_reg_n = 1'b1; ex_redirect = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;

    //   rn   rs1   rs2   u1    u2    rd    ld    wrn   rdr   req   rdy   exp    sc fe
    step(1'b0,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, C_RST, 0, 0, "reset");
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, C_Z,   0, 0, "idle");
    step(1'b1,5'd5, 5'd0, 1'b1,1'b0,5'd5, 1'b1,1'b0,1'b0,1'b0,1'b0, C_LU,  0, 0, "lu_rs1");
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, C_Z,   1, 0, "lu_done");
    step(1'b1,5'd0, 5'd0, 1'b1,1'b0,5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, C_Z,   1, 0, "lu_x0");
    step(1'b1,5'd3, 5'd7, 1'b1,1'b1,5'd7, 1'b1,1'b0,1'b0,1'b0,1'b0, C_LU,  1, 0, "lu_rs2");
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, C_Z,   2, 0, "idle2");
    step(1'b1,5'd5, 5'd0, 1'b0,1'b0,5'd5, 1'b1,1'b0,1'b0,1'b0,1'b0, C_Z,   2, 0, "lu_unused");
    step(1'b1,5'd5, 5'd0, 1'b1,1'b0,5'd5, 1'b1,1'b1,1'b0,1'b0,1'b0, C_Z,   2, 0, "lu_nowr");
    step(1'b1,5'd5, 5'd0, 1'b1,1'b0,5'd5, 1'b1,1'b0,1'b1,1'b0,1'b0, C_RD,  2, 0, "redir_lu");
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, C_Z,   2, 1, "redir_done");
    // dmem wait of three cycles, redirect/lu ignored while frozen
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b1,1'b0, C_MS,  2, 1, "mw1");
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b1,1'b1,1'b0, C_MS,  3, 1, "mw2_redir");
    step(1'b1,5'd5, 5'd0, 1'b1,1'b0,5'd5, 1'b1,1'b0,1'b0,1'b1,1'b0, C_MS,  4, 1, "mw3_lu");
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b1,1'b1, C_Z,   5, 1, "mw_release");
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, C_Z,   5, 1, "run_again");
    // release cycle applies redirect
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b1,1'b0, C_MS,  5, 1, "mw_b1");
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b1,1'b1,1'b1, C_RD,  6, 1, "rel_redir");
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, C_Z,   6, 2, "idle3");
    // watchdog: TIMEOUT=4, halt from the 5th cycle
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b1,1'b0, C_MS,  6, 2, "to1");
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b1,1'b0, C_MS,  7, 2, "to2");
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b1,1'b0, C_MS,  8, 2, "to3");
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b1,1'b0, C_MS,  9, 2, "to4");
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b1,1'b0, C_ERR, 10, 2, "err");
    step(1'b1,5'd5, 5'd0, 1'b1,1'b0,5'd5, 1'b1,1'b0,1'b1,1'b1,1'b1, C_ERR, 11, 2, "err_sticky");
    step(1'b0,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, C_RST, 12, 2, "err_reset");
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, C_Z,   0, 0, "after_reset");
    // reset while in MEM_WAIT
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b1,1'b0, C_MS,  0, 0, "mwr1");
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b1,1'b0, C_MS,  1, 0, "mwr2");
    step(1'b0,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b1,1'b0, C_RST, 2, 0, "mw_reset");
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b1,1'b1, C_Z,   0, 0, "req_ready");
    step(1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, C_Z,   0, 0, "final_idle");

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline: IF/ID, ID/EX, EX/MEM and MEM/WB registers plus the PC.
- Resolves load-use hazards, control redirects (jump/taken branch from EX) and multi-cycle data-memory waits.
- Drives per-stage stall (hold) and flush (bubble) enables.
- Keeps a memory-wait watchdog and stall/flush performance counters.

Parameters:
- TIMEOUT, 64, max consecutive dmem wait cycles before entering ERROR.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- id_rs1  in  5  rs1 of instruction in ID
- id_rs2  in  5  rs2 of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination register of instruction in EX
- ex_is_load  in  1  EX instruction is a load
- ex_wr_reg_n  in  1  EX instruction does not write the register file (active-low write)
- ex_redirect  in  1  EX jump or taken branch
- dmem_req  in  1  MEM stage issues a dmem access this cycle
- dmem_ready  in  1  dmem completes the access this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  load bubble into IF/ID
- id_ex_stall  out  1  hold ID/EX
- id_ex_flush  out  1  load bubble into ID/EX (wr_reg_n=1, jump=0)
- ex_mem_stall  out  1  hold EX/MEM
- mem_wb_flush  out  1  load bubble into MEM/WB
- halt  out  1  sticky error: dmem timeout
- stall_cycles  out  CNT_W  cycles with pc_stall=1
- flush_events  out  CNT_W  number of redirect flushes

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR; state register, wait counter and both performance counters update on posedge clk.
- Reset: rst_n=0 at a posedge forces state=RUN, wait_cnt=0, halt=0, stall_cycles=0, flush_events=0.
- Outputs are combinational from state and inputs. While rst_n=0 they are forced to: all stalls 0, if_id_flush=id_ex_flush=mem_wb_flush=1, halt=0.
- Load-use hazard (lu) = ex_is_load & !ex_wr_reg_n & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). Register x0 never causes a hazard.
- Memory stall (ms) = dmem_req & !dmem_ready.
- RUN, priority highest first:
  - ms: pc/if_id/id_ex/ex_mem stall=1, mem_wb_flush=1, no other flush. Next state MEM_WAIT, wait_cnt=1.
  - ex_redirect: if_id_flush=1, id_ex_flush=1, no stalls; flush_events+1. Redirect overrides lu in the same cycle because the ID instruction is discarded.
  - lu: pc_stall=1, if_id_stall=1, id_ex_flush=1. Exactly one bubble; the next cycle the load is in MEM and lu deasserts naturally.
  - Otherwise all outputs 0.
- MEM_WAIT:
  - Same outputs as ms for as long as dmem_ready=0.
  - Pipeline is frozen, so ex_redirect/lu are ignored and re-evaluated after release.
  - dmem_ready=1: release this cycle (no stall, RUN-priority rules apply to redirect/lu this same cycle); next state RUN, wait_cnt=0.
  - dmem_ready=0 and wait_cnt==TIMEOUT-1: next state ERROR.
  - Otherwise wait_cnt+1.
- ERROR: halt=1, all stalls 1, mem_wb_flush=1, inputs ignored; exit only via reset.
- stall_cycles increments every cycle pc_stall=1 (including ERROR); both counters wrap modulo 2^CNT_W.
- Reset mid-MEM_WAIT: outputs forced immediately; next cycle state RUN, no pending effects retained.
- wait_cnt width is $clog2(TIMEOUT+1); TIMEOUT>=2.

Decomposition:
- Shared pipeline package:
  - state encoding enum (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2)
  - REG_X0 constant
  - opcode constants already used by the pipeline registers
- One sub-module, hazard_perf_cnt: the two CNT_W counters with increment enables and synchronous clear.

Test Plan:
- lw x5 in EX (ex_rd=5, ex_is_load=1, ex_wr_reg_n=0), ID add using rs1=5 -> one cycle of pc_stall=if_id_stall=id_ex_flush=1, then all 0; stall_cycles=1.
- Same as above but ex_rd=0 -> no stall/flush.
- ex_redirect=1 together with lu=1 -> if_id_flush=id_ex_flush=1, pc_stall=0; flush_events=1.
- dmem_req=1, dmem_ready low for 3 cycles then high -> stalls and mem_wb_flush high for exactly 3 cycles, released on the 4th; stall_cycles=3; state back to RUN.
- TIMEOUT=4, dmem_ready held 0 -> halt=1 from the 5th cycle, outputs frozen; rst_n=0 for 1 cycle -> halt=0, counters 0, state RUN.
- rst_n=0 asserted during MEM_WAIT -> same cycle: flushes=1, stalls=0; after release, a new dmem_req with dmem_ready=1 -> no stall.
